// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel output stage.
// The Bayer helper is used only when VGA_DITHER_EN is defined.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Ordered 2x2 Bayer threshold; odd frames use the complemented matrix.
  function automatic logic [1:0] bayer_thr(input logic x0, input logic y0, input logic odd);
    logic [1:0] t;
    case ({y0, x0})
      2'b00:   t = 2'd0;
      2'b01:   t = 2'd2;
      2'b10:   t = 2'd3;
      default: t = 2'd1;
    endcase
    return odd ? ~t : t;
  endfunction

endpackage

// File: rtl/vga_pixel_out_if.sv
// Pixel-stage bus: generator/renderer/config inputs and pad-side outputs.
interface vga_pixel_out_if #(
  parameter int FRAME_W = 8
);
  logic               hs_i;
  logic               vs_i;
  logic               of_i;
  logic [9:0]         x_i;
  logic [9:0]         y_i;
  logic [11:0]        color_i;
  logic               cfg_we;
  logic               cfg_en;
  logic [11:0]        cfg_bg;
  logic [1:0]         r_o;
  logic [1:0]         g_o;
  logic [1:0]         b_o;
  logic               hs_o;
  logic               vs_o;
  logic [FRAME_W-1:0] frame_o;

  modport master (
    output hs_i, vs_i, of_i, x_i, y_i, color_i, cfg_we, cfg_en, cfg_bg,
    input  r_o, g_o, b_o, hs_o, vs_o, frame_o
  );

  modport slave (
    input  hs_i, vs_i, of_i, x_i, y_i, color_i, cfg_we, cfg_en, cfg_bg,
    output r_o, g_o, b_o, hs_o, vs_o, frame_o
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a configurable value.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg_p[i] <= RESET_VAL;
    end else begin
      stg_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stg_p[i] <= stg_p[i-1];
    end
  end

  assign dout = stg_p[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// Final VGA pixel stage: realigns syncs to renderer color, blanks, reduces to RGB222.
// Optional ordered 2x2 dither before reduction when VGA_DITHER_EN is defined.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int LATENCY  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int FRAME_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  vga_pixel_out_if.slave bus
);

`ifdef VGA_DITHER_EN
  localparam int             TUP_W   = 5;
  localparam logic [TUP_W-1:0] TUP_RST = 5'b11000;
`else
  localparam int             TUP_W   = 3;
  localparam logic [TUP_W-1:0] TUP_RST = 3'b110;
`endif

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

`ifdef VGA_DITHER_EN
  function automatic logic [1:0] sat_reduce(input logic [3:0] c, input logic [1:0] t);
    logic [4:0] s;
    s = {1'b0, c} + {3'b000, t};
    return s[4] ? 2'b11 : s[3:2];
  endfunction
`else
  function automatic logic [1:0] trunc_reduce(input logic [3:0] c);
    return c[3:2];
  endfunction
`endif

  // Stage p0: active flag and tuple formed at the input
  logic             act_p0;
  logic [TUP_W-1:0] tup_p0;

  assign act_p0 = (bus.x_i < H_LIM) && (bus.y_i < V_LIM);
`ifdef VGA_DITHER_EN
  assign tup_p0 = {bus.hs_i, bus.vs_i, act_p0, bus.x_i[0], bus.y_i[0]};
`else
  assign tup_p0 = {bus.hs_i, bus.vs_i, act_p0};
`endif

  // Stage p1: tuple delayed to line up with the renderer color
  logic [TUP_W-1:0] tup_p1;
  logic             hs_p1, vs_p1, act_p1;

  vga_delay_line #(
    .WIDTH    (TUP_W),
    .DEPTH    (LATENCY),
    .RESET_VAL(TUP_RST)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .din (tup_p0),
    .dout(tup_p1)
  );

  assign hs_p1  = tup_p1[TUP_W-1];
  assign vs_p1  = tup_p1[TUP_W-2];
  assign act_p1 = tup_p1[TUP_W-3];

  logic               sh_en, live_en;
  rgb444_t            sh_bg, live_bg;
  logic [FRAME_W-1:0] frame_q;

  // A write landing on the commit cycle goes straight to live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en   <= 1'b1;
      sh_bg   <= '0;
      live_en <= 1'b1;
      live_bg <= '0;
    end else begin
      if (bus.cfg_we) begin
        sh_en <= bus.cfg_en;
        sh_bg <= rgb444_t'(bus.cfg_bg);
      end
      if (bus.of_i) begin
        live_en <= bus.cfg_we ? bus.cfg_en : sh_en;
        live_bg <= bus.cfg_we ? rgb444_t'(bus.cfg_bg) : sh_bg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_q <= '0;
    else if (bus.of_i) frame_q <= frame_q + 1'b1;
  end

  rgb444_t src_p1;
  rgb222_t px_p1;
`ifdef VGA_DITHER_EN
  logic [1:0] thr_p1;
`endif

  always_comb begin
    src_p1 = live_en ? rgb444_t'(bus.color_i) : live_bg;
`ifdef VGA_DITHER_EN
    thr_p1  = bayer_thr(tup_p1[1], tup_p1[0], frame_q[0]);
    px_p1.r = sat_reduce(src_p1.r, thr_p1);
    px_p1.g = sat_reduce(src_p1.g, thr_p1);
    px_p1.b = sat_reduce(src_p1.b, thr_p1);
`else
    px_p1.r = trunc_reduce(src_p1.r);
    px_p1.g = trunc_reduce(src_p1.g);
    px_p1.b = trunc_reduce(src_p1.b);
`endif
    if (!act_p1) px_p1 = '0;
  end

  // Stage p2: output register toward the pads
  rgb222_t px_p2;
  logic    hs_p2, vs_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_p2 <= '0;
      hs_p2 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      px_p2 <= px_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  assign bus.r_o     = px_p2.r;
  assign bus.g_o     = px_p2.g;
  assign bus.b_o     = px_p2.b;
  assign bus.hs_o    = hs_p2;
  assign bus.vs_o    = vs_p2;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Scoreboard bench for vga_pixel_out on a sparse raster of boundary coordinates.
module tb_vga_pixel_out;

  localparam int LAT = 2;
  localparam int FW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pixel_out_if #(.FRAME_W(FW)) bus ();

  vga_pixel_out #(
    .LATENCY (LAT),
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .FRAME_W (FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        x0;
    logic        y0;
    logic [11:0] col;
  } hent_t;

  typedef struct packed {
    logic [5:0]    rgb;
    logic [1:0]    sync;
    logic [FW-1:0] frame;
  } exp_t;

  hent_t hist[$];
  exp_t  eq[$];

  logic          m_sh_en, m_live_en;
  logic [11:0]   m_sh_bg, m_live_bg;
  logic [FW-1:0] m_frame;

  int n_chk = 0;
  int n_err = 0;

  int xs[10] = '{0, 1, 2, 3, 638, 639, 640, 641, 700, 799};
  int ys[7]  = '{0, 1, 478, 479, 480, 490, 524};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

`ifdef VGA_DITHER_EN
  function automatic logic [5:0] m_px(input logic [11:0] c, input logic x0, input logic y0,
                                      input logic odd);
    int t, s;
    logic [5:0] o;
    case ({x0, y0})
      2'b00:   t = 0;
      2'b10:   t = 2;
      2'b01:   t = 3;
      default: t = 1;
    endcase
    if (odd) t = 3 - t;
    for (int k = 0; k < 3; k++) begin
      s = int'(c[11-4*k -: 4]) + t;
      if (s > 15) s = 15;
      o[5-2*k -: 2] = 2'(s / 4);
    end
    return o;
  endfunction
`else
  function automatic logic [5:0] m_px(input logic [11:0] c);
    return {c[11:10], c[7:6], c[3:2]};
  endfunction
`endif

  task automatic model_reset();
    hent_t h;
    exp_t  e;
    eq.delete();
    hist.delete();
    h = '0;
    h.hs = 1'b1;
    h.vs = 1'b1;
    for (int i = 0; i < LAT; i++) hist.push_back(h);
    e.rgb   = 6'd0;
    e.sync  = 2'b11;
    e.frame = '0;
    eq.push_back(e);
    m_sh_en   = 1'b1;
    m_live_en = 1'b1;
    m_sh_bg   = 12'h000;
    m_live_bg = 12'h000;
    m_frame   = '0;
  endtask

  // Asynchronous assertion between clock edges; outputs must react immediately.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb",   32'({bus.r_o, bus.g_o, bus.b_o}), 32'd0);
    chk("rst_sync",  32'({bus.hs_o, bus.vs_o}), 32'd3);
    chk("rst_frame", 32'(bus.frame_o), 32'd0);
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic of,
                      input logic we, input logic en, input logic [11:0] bg, input int mode);
    hent_t cur, dl;
    exp_t  e;
    logic [11:0] src;
    @(negedge clk);
    rst = 1'b0;
    if (eq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = eq.pop_front();
      chk("rgb",   32'({bus.r_o, bus.g_o, bus.b_o}), 32'(e.rgb));
      chk("sync",  32'({bus.hs_o, bus.vs_o}), 32'(e.sync));
      chk("frame", 32'(bus.frame_o), 32'(e.frame));
    end
    cur.hs  = (x != 10'd700);
    cur.vs  = (y != 10'd490);
    cur.act = (x < 10'd640) && (y < 10'd480);
    cur.x0  = x[0];
    cur.y0  = y[0];
    cur.col = (mode == 0) ? 12'hFFF : (mode == 2) ? 12'h555 : 12'($urandom_range(0, 4095));
    hist.push_back(cur);
    dl = hist.pop_front();

    bus.x_i     = x;
    bus.y_i     = y;
    bus.hs_i    = cur.hs;
    bus.vs_i    = cur.vs;
    bus.of_i    = of;
    bus.cfg_we  = we;
    bus.cfg_en  = we ? en : 1'b0;
    bus.cfg_bg  = we ? bg : 12'h000;
    bus.color_i = dl.col;

    src = m_live_en ? dl.col : m_live_bg;
`ifdef VGA_DITHER_EN
    e.rgb = dl.act ? m_px(src, dl.x0, dl.y0, m_frame[0]) : 6'd0;
`else
    e.rgb = dl.act ? m_px(src) : 6'd0;
`endif
    e.sync  = {dl.hs, dl.vs};
    e.frame = m_frame + FW'(of);
    eq.push_back(e);

    if (of) begin
      m_live_en = we ? en : m_sh_en;
      m_live_bg = we ? bg : m_sh_bg;
      m_frame   = m_frame + 1'b1;
    end
    if (we) begin
      m_sh_en = en;
      m_sh_bg = bg;
    end
  endtask

  task automatic run_frame(input int mode, input int cfg_at, input logic en,
                           input logic [11:0] bg, input int max_px);
    int p;
    p = 0;
    for (int yi = 0; yi < 7; yi++) begin
      for (int xi = 0; xi < 10; xi++) begin
        if (p >= max_px) return;
        step(10'(xs[xi]), 10'(ys[yi]), p == 69, p == cfg_at, en, bg, mode);
        p++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    bus.x_i     = '0;
    bus.y_i     = '0;
    bus.hs_i    = 1'b1;
    bus.vs_i    = 1'b1;
    bus.of_i    = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_en  = 1'b0;
    bus.cfg_bg  = '0;
    bus.color_i = '0;

    do_reset();
    run_frame(0, -1, 1'b0, 12'h000, 70);
    run_frame(1, -1, 1'b0, 12'h000, 25);
    do_reset();

    run_frame(0, -1, 1'b0, 12'h000, 70);
    run_frame(1, 20, 1'b0, 12'h840, 70);
    run_frame(1, 69, 1'b0, 12'h0C0, 70);
    run_frame(2, 30, 1'b1, 12'h000, 70);
    for (int f = 5; f <= 256; f++) begin
      run_frame(((f >> 1) & 1) != 0 ? 2 : 1, -1, 1'b0, 12'h000, 70);
    end

    step(10'd800, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 0);
    chk("wrap", 32'(bus.frame_o), 32'd0);
    for (int i = 0; i <= LAT; i++) step(10'd800, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
